pll_reset_sequencer: RTL and testbench

Sequences the ADC PLL (refclk → five output clocks) through reset, lock acquisition and lock qualification. It then releases the per-clock-domain resets in a fixed staggered order. It also detects loss of lock, retries failed lock attempts, and reports fault and status to the control logic. It runs entirely on the free-running 50 MHz reference clock and sits between the board reset and the PLL wrapper and its downstream domains.

---
 rtl/pll_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: resets the PLL, qualifies lock, then releases the
// per-domain resets in a staggered order. Watches for lock loss and retries failed lock attempts.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 50000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGGER_CYCLES     = 8,
   parameter int NUM_DOMAINS        = 5,
   parameter int MAX_RETRIES        = 3
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   restart,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   ready,
   output logic                   fault,
   output logic [2:0]             state,
   output logic [3:0]             retry_cnt,
   output logic [7:0]             loss_cnt
);

   // state     | meaning
   // ----------+-----------------------------------------------------------
   // RESET_PLL | pll_rst held for PLL_RST_CYCLES, all domains in reset
   // WAIT_LOCK | waiting for synced lock, timeout counter running
   // STABLE    | counting consecutive lock cycles before release
   // RELEASE   | releasing domain resets one by one, STAGGER_CYCLES apart
   // RUN       | all domains out of reset, ready asserted
   // FAULT     | retries exhausted, PLL held in reset until restart
   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   localparam int T1   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int T2   = (T1 > LOCK_STABLE_CYCLES) ? T1 : LOCK_STABLE_CYCLES;
   localparam int T3   = (NUM_DOMAINS - 1) * STAGGER_CYCLES + 1;
   localparam int TMAX = (T2 > T3) ? T2 : T3;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int IW   = $clog2(NUM_DOMAINS + 1);

   state_t                 state_q, state_nxt;
   logic [TW-1:0]          tmr, tmr_nxt;
   logic [IW-1:0]          rel_idx, idx_nxt;
   logic [NUM_DOMAINS-1:0] dom_nxt;
   logic [3:0]             retry_nxt, retry_inc;
   logic [7:0]             loss_nxt;
   logic                   sync1, lock_s, lost;

   assign state     = state_q;
   assign retry_inc = retry_cnt + 4'd1;
   assign lost      = !lock_s && (state_q == RELEASE || state_q == RUN);

   always_comb begin
      state_nxt = state_q;
      tmr_nxt   = tmr + TW'(1);
      idx_nxt   = rel_idx;
      dom_nxt   = domain_rst_n;
      retry_nxt = retry_cnt;
      loss_nxt  = loss_cnt;
      if (restart) begin
         state_nxt = RESET_PLL;
         tmr_nxt   = '0;
         dom_nxt   = '0;
         retry_nxt = '0;
      end else if (lost) begin
         state_nxt = RESET_PLL;
         tmr_nxt   = '0;
         dom_nxt   = '0;
         if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
      end else begin
         case (state_q)
            RESET_PLL: begin
               dom_nxt = '0;
               if (tmr == TW'(PLL_RST_CYCLES - 1)) begin
                  state_nxt = WAIT_LOCK;
                  tmr_nxt   = '0;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = STABLE;
                  tmr_nxt   = '0;
               end else if (tmr == TW'(LOCK_TIMEOUT - 1)) begin
                  retry_nxt = retry_inc;
                  tmr_nxt   = '0;
                  state_nxt = (retry_inc == 4'(MAX_RETRIES)) ? FAULT : RESET_PLL;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state_nxt = WAIT_LOCK;
                  tmr_nxt   = '0;
               end else if (tmr == TW'(LOCK_STABLE_CYCLES - 1)) begin
                  state_nxt = RELEASE;
                  tmr_nxt   = '0;
                  idx_nxt   = '0;
               end
            end
            RELEASE: begin
               // tmr is the stagger counter c; domain i goes when c == i*STAGGER_CYCLES
               if (rel_idx == IW'(NUM_DOMAINS)) begin
                  state_nxt = RUN;
               end else if (int'(tmr) == int'(rel_idx) * STAGGER_CYCLES) begin
                  for (int i = 0; i < NUM_DOMAINS; i++)
                     if (int'(rel_idx) == i) dom_nxt[i] = 1'b1;
                  idx_nxt = rel_idx + IW'(1);
               end
            end
            RUN: begin
               tmr_nxt = tmr;
            end
            FAULT: begin
               tmr_nxt = tmr;
               dom_nxt = '0;
            end
            default: begin
               state_nxt = RESET_PLL;
               tmr_nxt   = '0;
               dom_nxt   = '0;
            end
         endcase
      end
      if (state_nxt == RUN) retry_nxt = '0;
   end

   always_ff @(posedge refclk) begin
      if (!rst) begin
         sync1        <= 1'b0;
         lock_s       <= 1'b0;
         state_q      <= RESET_PLL;
         tmr          <= '0;
         rel_idx      <= '0;
         domain_rst_n <= '0;
         pll_rst      <= 1'b1;
         ready        <= 1'b0;
         fault        <= 1'b0;
         retry_cnt    <= '0;
         loss_cnt     <= '0;
      end else begin
         sync1        <= pll_locked;
         lock_s       <= sync1;
         state_q      <= state_nxt;
         tmr          <= tmr_nxt;
         rel_idx      <= idx_nxt;
         domain_rst_n <= dom_nxt;
         pll_rst      <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
         ready        <= (state_nxt == RUN);
         fault        <= (state_nxt == FAULT);
         retry_cnt    <= retry_nxt;
         loss_cnt     <= loss_nxt;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer. Edge Ek is the k-th rising edge
// sampled with rst=1; every check samples 1 time unit after an edge.
module tb_pll_reset_sequencer;
   localparam int NDOM = 5;

   logic            refclk = 1'b0;
   logic            rst = 1'b0;
   logic            pll_locked = 1'b0;
   logic            restart = 1'b0;
   logic            pll_rst;
   logic [NDOM-1:0] domain_rst_n;
   logic            ready;
   logic            fault;
   logic [2:0]      state;
   logic [3:0]      retry_cnt;
   logic [7:0]      loss_cnt;

   int n_chk = 0;
   int n_err = 0;
   int e = -1;
   bit ok;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES    (4),
      .LOCK_TIMEOUT      (100),
      .LOCK_STABLE_CYCLES(16),
      .STAGGER_CYCLES    (2),
      .NUM_DOMAINS       (NDOM),
      .MAX_RETRIES       (2)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .restart     (restart),
      .pll_rst     (pll_rst),
      .domain_rst_n(domain_rst_n),
      .ready       (ready),
      .fault       (fault),
      .state       (state),
      .retry_cnt   (retry_cnt),
      .loss_cnt    (loss_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic adv_to(input int k);
      while (e < k) begin
         @(posedge refclk);
         e++;
      end
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge refclk);
         e++;
         #1;
         if (state == s) begin
            hit = 1'b1;
            break;
         end
      end
   endtask

   // Hold rst low for two edges, check reset values, then release; next edge is E0.
   task automatic start_seq();
      rst = 1'b0;
      pll_locked = 1'b0;
      restart = 1'b0;
      @(posedge refclk);
      @(posedge refclk);
      #1;
      check_val("rst_state", state, 0);
      check_val("rst_pll_rst", pll_rst, 1);
      check_val("rst_dom", domain_rst_n, 0);
      check_val("rst_ready", ready, 0);
      check_val("rst_fault", fault, 0);
      check_val("rst_retry", retry_cnt, 0);
      check_val("rst_loss", loss_cnt, 0);
      rst = 1'b1;
      e = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Clean start: lock sampled at E10, first release at E10+19
      start_seq();
      adv_to(2);  check_val("cs_prst_e2", pll_rst, 1);
      adv_to(3);  check_val("cs_prst_e3", pll_rst, 0);
                  check_val("cs_wait_e3", state, 1);
      adv_to(9);  pll_locked = 1'b1;
      adv_to(11); check_val("cs_wait_e11", state, 1);
      adv_to(12); check_val("cs_stable_e12", state, 2);
      adv_to(27); check_val("cs_stable_e27", state, 2);
      adv_to(28); check_val("cs_release_e28", state, 3);
                  check_val("cs_dom_e28", domain_rst_n, 5'b00000);
      adv_to(29); check_val("cs_dom_e29", domain_rst_n, 5'b00001);
      adv_to(30); check_val("cs_dom_e30", domain_rst_n, 5'b00001);
      adv_to(31); check_val("cs_dom_e31", domain_rst_n, 5'b00011);
      adv_to(33); check_val("cs_dom_e33", domain_rst_n, 5'b00111);
      adv_to(35); check_val("cs_dom_e35", domain_rst_n, 5'b01111);
      adv_to(36); check_val("cs_dom_e36", domain_rst_n, 5'b01111);
      adv_to(37); check_val("cs_dom_e37", domain_rst_n, 5'b11111);
                  check_val("cs_ready_e37", ready, 0);
      adv_to(38); check_val("cs_ready_e38", ready, 1);
                  check_val("cs_run_e38", state, 4);
                  check_val("cs_retry_e38", retry_cnt, 0);

      // Glitchy lock: high E10..E17, low E18, high from E19
      start_seq();
      adv_to(9);  pll_locked = 1'b1;
      adv_to(17); pll_locked = 1'b0;
      adv_to(18); pll_locked = 1'b1;
      adv_to(19); check_val("gl_stable_e19", state, 2);
      adv_to(20); check_val("gl_wait_e20", state, 1);
      adv_to(21); check_val("gl_stable_e21", state, 2);
      adv_to(37); check_val("gl_release_e37", state, 3);
                  check_val("gl_dom_e37", domain_rst_n, 5'b00000);
      adv_to(38); check_val("gl_dom_e38", domain_rst_n, 5'b00001);
                  check_val("gl_loss_e38", loss_cnt, 0);
      adv_to(47); check_val("gl_ready_e47", ready, 1);

      // Loss in RUN: drop sampled at E50, domains reset at E52
      adv_to(49); pll_locked = 1'b0;
      adv_to(51); check_val("lr_dom_e51", domain_rst_n, 5'b11111);
                  check_val("lr_ready_e51", ready, 1);
      adv_to(52); check_val("lr_dom_e52", domain_rst_n, 5'b00000);
                  check_val("lr_ready_e52", ready, 0);
                  check_val("lr_loss_e52", loss_cnt, 1);
                  check_val("lr_state_e52", state, 0);
                  check_val("lr_prst_e52", pll_rst, 1);
      adv_to(55); check_val("lr_prst_e55", pll_rst, 1);
      adv_to(56); check_val("lr_prst_e56", pll_rst, 0);
                  check_val("lr_wait_e56", state, 1);
      adv_to(59); pll_locked = 1'b1;
      adv_to(79); check_val("lr_dom_e79", domain_rst_n, 5'b00001);
      adv_to(87); check_val("lr_dom_e87", domain_rst_n, 5'b11111);
                  check_val("lr_ready_e87", ready, 0);
      adv_to(88); check_val("lr_ready_e88", ready, 1);

      // restart coincident with lock loss: loss would land on E92
      adv_to(89); pll_locked = 1'b0;
      adv_to(91); restart = 1'b1;
      adv_to(92); check_val("rs_state_e92", state, 0);
                  check_val("rs_loss_e92", loss_cnt, 1);
                  check_val("rs_dom_e92", domain_rst_n, 5'b00000);
                  check_val("rs_ready_e92", ready, 0);
      restart = 1'b0;

      // Timeouts to fault with lock held low
      adv_to(95);  check_val("to_prst_e95", pll_rst, 1);
      adv_to(96);  check_val("to_wait_e96", state, 1);
      adv_to(195); check_val("to_retry_e195", retry_cnt, 0);
                   check_val("to_wait_e195", state, 1);
      adv_to(196); check_val("to_retry_e196", retry_cnt, 1);
                   check_val("to_state_e196", state, 0);
                   check_val("to_prst_e196", pll_rst, 1);
      adv_to(199); check_val("to_prst_e199", pll_rst, 1);
      adv_to(200); check_val("to_prst_e200", pll_rst, 0);
      adv_to(300); check_val("to_state_e300", state, 5);
                   check_val("to_fault_e300", fault, 1);
                   check_val("to_prst_e300", pll_rst, 1);
                   check_val("to_retry_e300", retry_cnt, 2);
      adv_to(305); check_val("to_hold_e305", state, 5);
      restart = 1'b1;
      adv_to(306); check_val("fr_state_e306", state, 0);
                   check_val("fr_fault_e306", fault, 0);
                   check_val("fr_retry_e306", retry_cnt, 0);
                   check_val("fr_prst_e306", pll_rst, 1);
      restart = 1'b0;

      // rst mid-RELEASE after three domains released
      adv_to(311); pll_locked = 1'b1;
      adv_to(335); check_val("mr_dom_e335", domain_rst_n, 5'b00111);
                   check_val("mr_state_e335", state, 3);
                   check_val("mr_loss_e335", loss_cnt, 1);
      rst = 1'b0;
      adv_to(336); check_val("mr_state_e336", state, 0);
                   check_val("mr_dom_e336", domain_rst_n, 5'b00000);
                   check_val("mr_loss_e336", loss_cnt, 0);
                   check_val("mr_prst_e336", pll_rst, 1);
                   check_val("mr_ready_e336", ready, 0);
      rst = 1'b1;

      // Saturation: force 300 losses, each from RELEASE
      for (int i = 0; i < 300; i++) begin
         wait_state(3'd3, 200, ok);
         if (!ok) begin
            check_val("sat_wait_release", ok, 1);
            break;
         end
         pll_locked = 1'b0;
         repeat (4) @(posedge refclk);
         #1;
         pll_locked = 1'b1;
         if (i == 99)  check_val("sat_loss_100", loss_cnt, 100);
         if (i == 254) check_val("sat_loss_255", loss_cnt, 255);
      end
      check_val("sat_loss_300", loss_cnt, 255);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
